// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default vectors for the program-counter generator
package pc_pkg;

  typedef enum logic {
    RUN,
    HANDLER
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_MRET,
    SEL_REDIR,
    SEL_HOLD,
    SEL_RAS,
    SEL_SEQ
  } pc_sel_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [PW:0]     count_q;

  // push+pop together replaces the top entry in place; pointer and count stay put
  always_ff @(posedge clk) begin
    if (push) begin
      if (pop) mem[ptr_q] <= push_data;
      else     mem[ptr_q + 1'b1] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (push && !pop) begin
      ptr_q <= ptr_q + 1'b1;
      if (!full) count_q <= count_q + 1'b1;
    end else if (pop && !push) begin
      ptr_q   <= ptr_q - 1'b1;
      count_q <= count_q - 1'b1;
    end
  end

  assign top   = mem[ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == (PW+1)'(DEPTH));

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - prioritised next-PC selector with trap/EPC handling and return-address stack
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
  parameter int              ILEN_BYTES   = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
  input  logic            mret,
  input  logic            call_push,
  input  logic [XLEN-1:0] call_ret_addr,
  input  logic            ret_pop,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic [XLEN-1:0] epc,
  output logic            in_handler,
  output logic            misaligned,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int ALIGN_W = $clog2(ILEN_BYTES);

  pc_state_e       state_q, state_d;
  pc_sel_e         sel;
  logic [XLEN-1:0] pc_q, pc_d, epc_q;
  logic [XLEN-1:0] ras_top;
  logic            epc_save, mis_d, mis_q;
  logic            ras_en, ras_push, ras_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      if (epc_save) epc_q <= pc_q;
    end
  end

  always_comb begin
    sel      = SEL_SEQ;
    state_d  = state_q;
    epc_save = 1'b0;
    mis_d    = 1'b0;
    if (trap) begin
      sel = SEL_TRAP;
      if (state_q == RUN) begin
        state_d  = HANDLER;
        epc_save = 1'b1;
      end
    end else if (mret && state_q == HANDLER) begin
      sel     = SEL_MRET;
      state_d = RUN;
    end else if (redirect_valid) begin
      // a misaligned target always records the redirecting PC, even when nested
      if (redirect_target[ALIGN_W-1:0] != '0) begin
        sel      = SEL_TRAP;
        state_d  = HANDLER;
        epc_save = 1'b1;
        mis_d    = 1'b1;
      end else begin
        sel = SEL_REDIR;
      end
    end else if (stall) begin
      sel = SEL_HOLD;
    end else if (ret_pop && !ras_empty) begin
      sel = SEL_RAS;
    end
  end

  always_comb begin
    pc_d = pc_plus_inc;
    case (sel)
      SEL_TRAP:  pc_d = TRAP_VECTOR;
      SEL_MRET:  pc_d = epc_q;
      SEL_REDIR: pc_d = redirect_target;
      SEL_HOLD:  pc_d = pc_q;
      SEL_RAS:   pc_d = ras_top;
      default:   pc_d = pc_plus_inc;
    endcase
  end

  assign ras_en   = (sel == SEL_RAS) || (sel == SEL_SEQ);
  assign ras_push = ras_en && call_push;
  assign ras_pop  = ras_en && ret_pop && !ras_empty;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (call_ret_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign pc_out      = pc_q;
  assign pc_plus_inc = pc_q + XLEN'(ILEN_BYTES);
  assign epc         = epc_q;
  assign in_handler  = (state_q == HANDLER);
  assign misaligned  = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench: queue-based reference model plus directed literal checks
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, redirect_valid = 1'b0, trap = 1'b0, mret = 1'b0;
  logic        call_push = 1'b0, ret_pop = 1'b0;
  logic [31:0] redirect_target = '0, call_ret_addr = '0;
  logic [31:0] pc_out, pc_plus_inc, epc;
  logic        in_handler, misaligned, ras_empty, ras_full;

  int n_cmp = 0;
  int n_bad = 0;

  pc_gen dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap            (trap),
    .mret            (mret),
    .call_push       (call_push),
    .call_ret_addr   (call_ret_addr),
    .ret_pop         (ret_pop),
    .pc_out          (pc_out),
    .pc_plus_inc     (pc_plus_inc),
    .epc             (epc),
    .in_handler      (in_handler),
    .misaligned      (misaligned),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: PC, EPC, handler flag and the RAS as a queue (newest at the back)
  logic [31:0] m_pc = 32'h0, m_epc = 32'h0;
  logic        m_h = 1'b0, m_mis = 1'b0;
  logic [31:0] m_ras[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h0; m_epc = 32'h0; m_h = 1'b0; m_mis = 1'b0;
      m_ras.delete();
    end else begin
      m_mis = 1'b0;
      if (trap) begin
        if (!m_h) begin m_epc = m_pc; m_h = 1'b1; end
        m_pc = 32'h100;
      end else if (mret && m_h) begin
        m_pc = m_epc; m_h = 1'b0;
      end else if (redirect_valid) begin
        if (redirect_target % 4 != 0) begin
          m_epc = m_pc; m_h = 1'b1; m_pc = 32'h100; m_mis = 1'b1;
        end else begin
          m_pc = redirect_target;
        end
      end else if (stall) begin
        m_pc = m_pc;
      end else if (ret_pop && m_ras.size() > 0) begin
        m_pc = m_ras[$];
        if (call_push) m_ras[$] = call_ret_addr;
        else void'(m_ras.pop_back());
      end else begin
        if (call_push) begin
          m_ras.push_back(call_ret_addr);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("pc_out", pc_out, m_pc);
      chk("pc_plus_inc", pc_plus_inc, m_pc + 32'd4);
      chk("epc", epc, m_epc);
      chk("in_handler", {31'b0, in_handler}, {31'b0, m_h});
      chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
      chk("ras_empty", {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
      chk("ras_full", {31'b0, ras_full}, {31'b0, m_ras.size() == 4});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; redirect_valid = 0; trap = 0; mret = 0; call_push = 0; ret_pop = 0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_empty", {31'b0, ras_empty}, 32'h1);
    chk("rst_full", {31'b0, ras_full}, 32'h0);
    chk("rst_handler", {31'b0, in_handler}, 32'h0);
    chk("rst_mis", {31'b0, misaligned}, 32'h0);
    rst = 0;
    chk("seq0", pc_out, 32'h0);
    chk("inc0", pc_plus_inc, 32'h4);
    tick(); chk("seq1", pc_out, 32'h4);
    tick(); chk("seq2", pc_out, 32'h8);

    redirect_valid = 1; redirect_target = 32'h40; stall = 1;
    tick(); chk("redir_over_stall", pc_out, 32'h40);
    redirect_valid = 0;
    tick(); chk("stall_hold", pc_out, 32'h40);
    idle();

    trap = 1;
    tick(); chk("trap_pc", pc_out, 32'h100); chk("trap_epc", epc, 32'h40);
    chk("trap_h", {31'b0, in_handler}, 32'h1);
    tick(); chk("nest_pc", pc_out, 32'h100); chk("nest_epc", epc, 32'h40);
    trap = 0; mret = 1;
    tick(); chk("mret_pc", pc_out, 32'h40); chk("mret_h", {31'b0, in_handler}, 32'h0);
    tick(); chk("mret_run", pc_out, 32'h44);
    idle();

    redirect_valid = 1; redirect_target = 32'h10;
    tick(); chk("redir_ok", pc_out, 32'h10);
    redirect_target = 32'h42;
    tick(); chk("mis_pc", pc_out, 32'h100); chk("mis_epc", epc, 32'h10);
    chk("mis_flag", {31'b0, misaligned}, 32'h1); chk("mis_h", {31'b0, in_handler}, 32'h1);
    idle();
    tick(); chk("mis_pulse", {31'b0, misaligned}, 32'h0);
    mret = 1;
    tick(); chk("mis_ret", pc_out, 32'h10);
    idle();

    call_push = 1;
    for (int i = 1; i <= 5; i++) begin
      call_ret_addr = 32'(i) << 12;
      tick();
      if (i == 4) chk("full_at4", {31'b0, ras_full}, 32'h1);
    end
    call_push = 0; ret_pop = 1;
    for (int i = 5; i >= 2; i--) begin
      tick(); chk("pop_seq", pc_out, 32'(i) << 12);
    end
    chk("pop_empty", {31'b0, ras_empty}, 32'h1);
    tick(); chk("pop_underflow", pc_out, 32'h2004);
    idle();

    call_push = 1; call_ret_addr = 32'h2000;
    tick();
    ret_pop = 1; call_ret_addr = 32'h3000;
    tick(); chk("pushpop_pc", pc_out, 32'h2000); chk("pushpop_cnt", {31'b0, ras_empty}, 32'h0);
    call_push = 0;
    tick(); chk("pushpop_next", pc_out, 32'h3000);
    idle();

    call_push = 1; call_ret_addr = 32'h7000;
    tick();
    call_push = 0; stall = 1; ret_pop = 1;
    tick(); chk("stall_blocks_pop", {31'b0, ras_empty}, 32'h0);
    idle();

    redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
    tick(); chk("wrap_inc", pc_plus_inc, 32'h0);
    idle();
    tick(); chk("wrap_pc", pc_out, 32'h0);

    trap = 1;
    tick(); idle();
    #2 rst = 1;
    #1;
    chk("async_pc", pc_out, 32'h0); chk("async_epc", epc, 32'h0);
    chk("async_empty", {31'b0, ras_empty}, 32'h1); chk("async_h", {31'b0, in_handler}, 32'h0);
    tick();
    rst = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
